rstn_sequencer: RTL



---
 rtl/rstn_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rstn_sequencer.sv
// rtl/rstn_sequencer.sv - reset stretcher and staggered release of active-low domain resets
// Async assert on RN, synchronized deassert, then timed per-domain release; SW request replays it.
module rstn_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 16,
   parameter int NUM_DOMAINS = 3,
   parameter int STAGE_GAP   = 4
) (
   input  logic                   CLK,
   input  logic                   RN,
   input  logic                   SW_RST_REQ,
   output logic [NUM_DOMAINS-1:0] RN_OUT,
   output logic                   RST_DONE,
   output logic                   SW_RST_ACK
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rstn_sequencer: SYNC_STAGES must be >= 2");
   end
   if (STRETCH < 1) begin : g_bad_stretch
      $error("rstn_sequencer: STRETCH must be >= 1");
   end
   if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
      $error("rstn_sequencer: NUM_DOMAINS must be 1..8");
   end
   if (STAGE_GAP < 1) begin : g_bad_gap
      $error("rstn_sequencer: STAGE_GAP must be >= 1");
   end

   localparam int CNT_TOP = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
   localparam int CNT_W   = $clog2(CNT_TOP + 1);
   // The SYNC->STRETCH state flop acts as the last synchronizer stage.
   localparam int CH_W    = SYNC_STAGES - 1;

   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_TOP);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [CH_W-1:0]        sync_q, sync_d;
   logic [NUM_DOMAINS-1:0] rn_out_q, rn_out_d;
   logic                   done_q, done_d;
   logic                   ack_q, ack_d;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q  <= ST_SYNC;
         cnt_q    <= '0;
         sync_q   <= '0;
         rn_out_q <= '0;
         done_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sync_q   <= sync_d;
         rn_out_q <= rn_out_d;
         done_q   <= done_d;
         ack_q    <= ack_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sync_d   = (sync_q << 1) | CH_W'(1);
      rn_out_d = rn_out_q;
      done_d   = done_q;
      ack_d    = 1'b0;
      cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         ST_SYNC: begin
            if (sync_q[CH_W-1]) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         ST_STRETCH: begin
            if (cnt_q == STRETCH_LAST) begin
               rn_out_d = NUM_DOMAINS'(1);
               state_d  = ST_RELEASE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RELEASE: begin
            // Domains fill from bit 0 upward, so the top bit marks the last release.
            if (rn_out_q[NUM_DOMAINS-1]) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               rn_out_d = (rn_out_q << 1) | NUM_DOMAINS'(1);
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DONE: begin
            if (SW_RST_REQ) begin
               rn_out_d = '0;
               done_d   = 1'b0;
               ack_d    = 1'b1;
               state_d  = ST_STRETCH;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   assign RN_OUT     = rn_out_q;
   assign RST_DONE   = done_q;
   assign SW_RST_ACK = ack_q;

endmodule
